postfix_eval_p: RTL and testbench

// - Parametrised postfix (RPN) expression evaluator; next generation of the lab postfix calculator.
// - Accepts a token stream (operands/operators), evaluates on an internal stack, reports result + error flag.
// - Adds over the previous generation: parametrised width/depth, overflow/underflow/illegal-op detection,
//   AND/XOR ops, clean async reset, back-to-back expressions.

---
 rtl/postfix_eval_p_pkg.sv | 22 ++
 rtl/postfix_eval_p_if.sv | 15 +
 rtl/postfix_eval_p_alu.sv | 27 ++
 rtl/postfix_eval_p.sv | 124 ++++++++++++
 tb/tb_postfix_eval_p.sv | 138 +++++++++++++
 5 files changed

// File: rtl/postfix_eval_p_pkg.sv
// Shared definitions for the postfix evaluator: opcode encodings, FSM states
// and the opcode legality check.
package postfix_pkg;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_MUL = 4'b0100;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_XOR = 4'b0011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_ERR
    } state_t;

    function automatic logic is_legal_op(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_MUL) ||
               (op == OP_AND) || (op == OP_XOR);
    endfunction

endpackage

// File: rtl/postfix_eval_p_if.sv
// Token/result bus between a token source (master) and the evaluator (slave).
interface postfix_eval_p_if #(
    parameter int DATA_W = 16,
    parameter int IN_W   = 4
);
    logic              IN_VALID;
    logic              OP_MODE;
    logic [IN_W-1:0]   IN;
    logic              OUT_VALID;
    logic [DATA_W-1:0] OUT;
    logic              OUT_ERR;

    modport master (output IN_VALID, OP_MODE, IN, input OUT_VALID, OUT, OUT_ERR);
    modport slave  (input IN_VALID, OP_MODE, IN, output OUT_VALID, OUT, OUT_ERR);
endinterface

// File: rtl/postfix_eval_p_alu.sv
// Combinational operator unit: result = b <op> a, truncated to DATA_W bits.
module postfix_alu
    import postfix_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic              illegal
);

    always_comb begin
        result  = '0;
        illegal = !is_legal_op(op);
        case (op)
            OP_ADD:  result = b + a;
            OP_SUB:  result = b - a;
            OP_MUL:  result = b * a;
            OP_AND:  result = b & a;
            OP_XOR:  result = b ^ a;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/postfix_eval_p.sv
// Postfix (RPN) evaluator: token stream in, one registered result/error pulse
// per expression out. Expressions are delimited by runs of IN_VALID.
//
// state  | meaning
// S_IDLE | no expression in progress, stack empty
// S_RUN  | expression in progress, no fault so far
// S_ERR  | fault seen, tokens ignored until IN_VALID drops
module postfix_eval_p
    import postfix_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int IN_W   = 4,
    parameter int DEPTH  = 16
) (
    input logic              CLK,
    input logic              RESET,
    postfix_eval_p_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  count, count_nxt;
    logic [DATA_W-1:0] stack [DEPTH];

    logic [DATA_W-1:0] tok_ext;
    logic [IDX_W-1:0]  idx_a, idx_b, idx_push, wr_idx;
    logic [DATA_W-1:0] alu_result, wr_data;
    logic              alu_illegal, tok_fault, wr_en, emit, emit_ok;

    logic              out_valid_q, out_err_q;
    logic [DATA_W-1:0] out_q;

    assign tok_ext  = DATA_W'(bus.IN);
    assign idx_a    = IDX_W'(count - CNT_W'(1));
    assign idx_b    = IDX_W'(count - CNT_W'(2));
    assign idx_push = IDX_W'(count);

    postfix_alu #(.DATA_W(DATA_W)) u_alu (
        .a       (stack[idx_a]),
        .b       (stack[idx_b]),
        .op      (bus.IN[3:0]),
        .result  (alu_result),
        .illegal (alu_illegal)
    );

    // Opcode bits above the low nibble must be zero for a legal operator.
    always_comb begin
        if (bus.OP_MODE)
            tok_fault = (count < CNT_W'(2)) || alu_illegal || ((tok_ext >> 4) != '0);
        else
            tok_fault = (count == CNT_W'(DEPTH));
    end

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        wr_en     = 1'b0;
        wr_idx    = idx_push;
        wr_data   = tok_ext;
        emit      = 1'b0;
        emit_ok   = 1'b0;
        case (state)
            S_IDLE, S_RUN: begin
                if (bus.IN_VALID) begin
                    if (tok_fault) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_RUN;
                        wr_en     = 1'b1;
                        if (bus.OP_MODE) begin
                            wr_idx    = idx_b;
                            wr_data   = alu_result;
                            count_nxt = count - CNT_W'(1);
                        end else begin
                            count_nxt = count + CNT_W'(1);
                        end
                    end
                end else if (state == S_RUN) begin
                    emit      = 1'b1;
                    emit_ok   = (count == CNT_W'(1));
                    count_nxt = '0;
                    state_nxt = S_IDLE;
                end
            end
            S_ERR: begin
                if (!bus.IN_VALID) begin
                    emit      = 1'b1;
                    count_nxt = '0;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state       <= S_IDLE;
            count       <= '0;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            out_err_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            count       <= count_nxt;
            out_valid_q <= emit;
            out_q       <= (emit && emit_ok) ? stack[0] : '0;
            out_err_q   <= emit && !emit_ok;
        end
    end

    // Stack contents need no reset; count alone defines what is live.
    always_ff @(posedge CLK) begin
        if (wr_en)
            stack[wr_idx] <= wr_data;
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.OUT       = out_q;
    assign bus.OUT_ERR   = out_err_q;

endmodule

// File: tb/tb_postfix_eval_p.sv
// Directed-vector bench for postfix_eval_p (DATA_W=16, IN_W=4, DEPTH=16).
module tb_postfix_eval_p;

    localparam int DATA_W = 16;
    localparam int IN_W   = 4;
    localparam int DEPTH  = 16;

    logic CLK;
    logic RESET;
    int   checks = 0;
    int   errors = 0;

    postfix_eval_p_if #(.DATA_W(DATA_W), .IN_W(IN_W)) bus ();

    postfix_eval_p #(.DATA_W(DATA_W), .IN_W(IN_W), .DEPTH(DEPTH)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Token tasks drive at a falling edge and return on the next falling edge.
    task automatic push(input logic [IN_W-1:0] v);
        bus.IN_VALID = 1'b1;
        bus.OP_MODE  = 1'b0;
        bus.IN       = v;
        @(negedge CLK);
    endtask

    task automatic op(input logic [IN_W-1:0] code);
        bus.IN_VALID = 1'b1;
        bus.OP_MODE  = 1'b1;
        bus.IN       = code;
        @(negedge CLK);
    endtask

    // Ends the expression and checks the pulse; chain=1 returns inside the
    // pulse cycle so the caller can start the next expression there.
    task automatic finish_expr(input string tag, input logic [15:0] exp_out,
                               input logic exp_err, input bit chain);
        bus.IN_VALID = 1'b0;
        bus.OP_MODE  = 1'b0;
        bus.IN       = '0;
        @(negedge CLK);
        check({tag, ".valid"}, 32'(bus.OUT_VALID), 32'd1);
        check({tag, ".out"},   32'(bus.OUT),       32'(exp_out));
        check({tag, ".err"},   32'(bus.OUT_ERR),   32'(exp_err));
        if (!chain) begin
            @(negedge CLK);
            check({tag, ".valid_drop"}, 32'(bus.OUT_VALID), 32'd0);
            check({tag, ".out_drop"},   32'(bus.OUT),       32'd0);
        end
    endtask

    initial begin
        RESET        = 1'b0;
        bus.IN_VALID = 1'b0;
        bus.OP_MODE  = 1'b0;
        bus.IN       = '0;
        repeat (2) @(negedge CLK);
        check("rst.valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst.out",   32'(bus.OUT),       32'd0);
        check("rst.err",   32'(bus.OUT_ERR),   32'd0);
        RESET = 1'b1;
        @(negedge CLK);

        // (3+4)*2
        push(3); push(4); op(4'b0001); push(2); op(4'b0100);
        finish_expr("add_mul", 16'd14, 1'b0, 1'b0);

        // 2-5 wraps; next expression starts inside the pulse cycle
        push(2); push(5); op(4'b0010);
        finish_expr("sub_wrap", 16'hFFFD, 1'b0, 1'b1);

        // 15^5 = 759375 = 0xB964F, low 16 bits kept
        push(15); push(15); op(4'b0100);
        for (int i = 0; i < 3; i++) begin
            push(15); op(4'b0100);
        end
        finish_expr("mul_trunc", 16'h964F, 1'b0, 1'b0);

        push(3); op(4'b0001);
        finish_expr("underflow", 16'd0, 1'b1, 1'b0);

        for (int i = 0; i < 17; i++) push(1);
        op(4'b0001);
        finish_expr("overflow", 16'd0, 1'b1, 1'b0);

        // Exactly DEPTH entries is legal
        for (int i = 0; i < 16; i++) push(1);
        for (int i = 0; i < 15; i++) op(4'b0001);
        finish_expr("full_stack", 16'd16, 1'b0, 1'b0);

        push(1); push(2); op(4'b0101);
        finish_expr("illegal_op", 16'd0, 1'b1, 1'b0);

        push(1); push(2);
        finish_expr("leftover", 16'd0, 1'b1, 1'b0);

        push(6); push(7); op(4'b0011);
        finish_expr("xor", 16'd1, 1'b0, 1'b0);

        push(9); push(1); op(4'b0010);
        finish_expr("b2b_sub", 16'd8, 1'b0, 1'b0);
        push(12); push(10); op(4'b1000);
        finish_expr("b2b_and", 16'd8, 1'b0, 1'b0);

        // Reset in the middle of "5 6 ADD"
        push(5); push(6);
        RESET        = 1'b0;
        bus.IN_VALID = 1'b0;
        #1;
        check("midrst.valid_async", 32'(bus.OUT_VALID), 32'd0);
        @(negedge CLK);
        check("midrst.valid", 32'(bus.OUT_VALID), 32'd0);
        RESET = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("midrst.no_pulse", 32'(bus.OUT_VALID), 32'd0);
        end
        push(4); push(4); op(4'b0001);
        finish_expr("after_rst", 16'd8, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
